// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
//   Generates the traffic_state code consumed by pwm_driver. It steps
//   RED -> GREEN -> YELLOW -> RED, timing each phase in prescaler ticks.
//   Latched pedestrian requests shorten GREEN and are served by a walk RED.
//   An emergency input forces GREEN to YELLOW and holds RED.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   enable        runs the prescaler and phase timers; low freezes them
//   ped_req       pedestrian request (level or pulse)
//   emerg         emergency override (level)
//   traffic_state 00 RED, 01 GREEN, 10 YELLOW
//   remaining     ticks left in the current phase, including the current one
//   state_change  one-cycle pulse in the first cycle of a new phase
//   ped_ack       one-cycle pulse when a walk RED begins
//   ped_walk      high for the whole walk RED
//
// state  | meaning
// RED    | stop; walk phase when a request was pending at entry
// GREEN  | go; may end early on a pending request after MIN_GRN ticks
// YELLOW | clearance; always completes

module traffic_phase_ctrl #(
    parameter int unsigned TICK_DIV = 1000,
    parameter int unsigned RED_T    = 20,
    parameter int unsigned GRN_T    = 30,
    parameter int unsigned YEL_T    = 5,
    parameter int unsigned MIN_GRN  = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ped_req,
    input  logic             emerg,
    output logic [1:0]       traffic_state,
    output logic [CNT_W-1:0] remaining,
    output logic             state_change,
    output logic             ped_ack,
    output logic             ped_walk
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] RED_LD  = CNT_W'(RED_T);
    localparam logic [CNT_W-1:0] GRN_LD  = CNT_W'(GRN_T);
    localparam logic [CNT_W-1:0] YEL_LD  = CNT_W'(YEL_T);
    // A tick completing with remaining at or below this value brings the
    // elapsed GREEN ticks (including the one completing) up to MIN_GRN.
    localparam logic [CNT_W-1:0] EARLY_REM = CNT_W'(GRN_T + 1 - MIN_GRN);

    typedef enum logic [1:0] {
        ST_RED    = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             pending_q, pending_d;
    logic             emerg_q;
    logic             sc_q, sc_d;
    logic             ack_q, ack_d;
    logic             walk_q, walk_d;

    logic             tick;
    logic             go;
    state_e           nxt;

    assign tick = enable && (presc_q == PRE_MAX);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        presc_d   = presc_q;
        pending_d = pending_q;
        sc_d      = 1'b0;
        ack_d     = 1'b0;
        walk_d    = walk_q;
        go        = 1'b0;
        nxt       = state_q;

        if (enable) begin
            presc_d = (presc_q == PRE_MAX) ? '0 : presc_q + PRE_ONE;
        end

        if (ped_req && !walk_q) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            ST_RED: begin
                if (emerg_q && !emerg) begin
                    // Emergency just released: restart a full RED silently.
                    rem_d   = RED_LD;
                    presc_d = '0;
                end else if (tick) begin
                    if (rem_q != CNT_ONE) begin
                        rem_d = rem_q - CNT_ONE;
                    end else if (!emerg) begin
                        go  = 1'b1;
                        nxt = ST_GREEN;
                    end
                end
            end
            ST_GREEN: begin
                if (emerg) begin
                    go  = 1'b1;
                    nxt = ST_YELLOW;
                end else if (tick) begin
                    if (rem_q == CNT_ONE || (pending_q && rem_q <= EARLY_REM)) begin
                        go  = 1'b1;
                        nxt = ST_YELLOW;
                    end else begin
                        rem_d = rem_q - CNT_ONE;
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (rem_q == CNT_ONE) begin
                        go  = 1'b1;
                        nxt = ST_RED;
                    end else begin
                        rem_d = rem_q - CNT_ONE;
                    end
                end
            end
            default: begin
                go  = 1'b1;
                nxt = ST_RED;
            end
        endcase

        if (go) begin
            state_d = nxt;
            presc_d = '0;
            sc_d    = 1'b1;
            walk_d  = 1'b0;
            unique case (nxt)
                ST_GREEN:  rem_d = GRN_LD;
                ST_YELLOW: rem_d = YEL_LD;
                default: begin
                    rem_d     = RED_LD;
                    pending_d = 1'b0;
                    ack_d     = pending_q;
                    walk_d    = pending_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RED;
            rem_q     <= RED_LD;
            presc_q   <= '0;
            pending_q <= 1'b0;
            emerg_q   <= 1'b0;
            sc_q      <= 1'b0;
            ack_q     <= 1'b0;
            walk_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            presc_q   <= presc_d;
            pending_q <= pending_d;
            emerg_q   <= emerg;
            sc_q      <= sc_d;
            ack_q     <= ack_d;
            walk_q    <= walk_d;
        end
    end

    assign traffic_state = state_q;
    assign remaining     = rem_q;
    assign state_change  = sc_q;
    assign ped_ack       = ack_q;
    assign ped_walk      = walk_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with TICK_DIV=4, RED_T=3, GRN_T=5,
// YEL_T=2, MIN_GRN=2. Inputs change and outputs are sampled on the falling
// clock edge, so every rising edge sees stable stimulus.

module tb_traffic_phase_ctrl;

    localparam int CNT_W = 16;
    localparam logic [1:0] RED = 2'b00;
    localparam logic [1:0] GRN = 2'b01;
    localparam logic [1:0] YEL = 2'b10;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             ped_req;
    logic             emerg;
    logic [1:0]       traffic_state;
    logic [CNT_W-1:0] remaining;
    logic             state_change;
    logic             ped_ack;
    logic             ped_walk;

    int n_chk  = 0;
    int n_fail = 0;

    traffic_phase_ctrl #(
        .TICK_DIV (4),
        .RED_T    (3),
        .GRN_T    (5),
        .YEL_T    (2),
        .MIN_GRN  (2),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .ped_req       (ped_req),
        .emerg         (emerg),
        .traffic_state (traffic_state),
        .remaining     (remaining),
        .state_change  (state_change),
        .ped_ack       (ped_ack),
        .ped_walk      (ped_walk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count cycles until the next state_change pulse, then check the new state.
    task automatic meas(input string tag, input logic [1:0] exp_st, input int exp_n);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!state_change && n < 200);
        chk({tag, " len"}, n, exp_n);
        chk({tag, " st"}, {30'b0, traffic_state}, {30'b0, exp_st});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        ped_req = 1'b0;
        emerg   = 1'b0;
        adv(3);
        chk("rst st",   {30'b0, traffic_state}, 0);
        chk("rst rem",  remaining, 3);
        chk("rst sc",   state_change, 0);
        chk("rst ack",  ped_ack, 0);
        chk("rst walk", ped_walk, 0);
        rst = 1'b0;

        // 1: free-running sequence
        adv(3);
        chk("t1 rem3", remaining, 3);
        adv(1);
        chk("t1 rem2", remaining, 2);
        adv(4);
        chk("t1 rem1", remaining, 1);
        meas("t1 red", GRN, 4);
        chk("t1 grn rem", remaining, 5);
        adv(1);
        chk("t1 sc clr", state_change, 0);
        meas("t1 grn", YEL, 19);
        chk("t1 yel rem", remaining, 2);
        meas("t1 yel", RED, 8);
        chk("t1 red rem", remaining, 3);
        chk("t1 no ack", ped_ack, 0);

        // 2: request in first GREEN cycle shortens GREEN to 8 cycles
        meas("t2 red", GRN, 12);
        ped_req = 1'b1;
        adv(1);
        ped_req = 1'b0;
        meas("t2 grn", YEL, 7);
        meas("t2 yel", RED, 8);
        chk("t2 ack", ped_ack, 1);
        chk("t2 walk", ped_walk, 1);
        adv(1);
        chk("t2 ack once", ped_ack, 0);
        chk("t2 walk hold", ped_walk, 1);
        ped_req = 1'b1;
        adv(1);
        ped_req = 1'b0;
        adv(9);
        chk("t2 walk end", ped_walk, 1);
        chk("t2 still red", {30'b0, traffic_state}, 0);
        meas("t2 walk red", GRN, 1);
        chk("t2 walk off", ped_walk, 0);
        meas("t2 grn full", YEL, 20);
        meas("t2 yel2", RED, 8);
        chk("t2 no ack", ped_ack, 0);
        chk("t2 no walk", ped_walk, 0);

        // 3: request with remaining=2 ends GREEN at the next tick (16 cycles)
        meas("t3 red", GRN, 12);
        adv(12);
        chk("t3 rem2", remaining, 2);
        ped_req = 1'b1;
        adv(1);
        ped_req = 1'b0;
        meas("t3 grn", YEL, 3);
        meas("t3 yel", RED, 8);
        chk("t3 ack", ped_ack, 1);
        meas("t3 walk red", GRN, 12);

        // 4: emergency from GREEN, hold in RED, release
        adv(4);
        chk("t4 rem4", remaining, 4);
        emerg = 1'b1;
        adv(1);
        chk("t4 yel st", {30'b0, traffic_state}, 2);
        chk("t4 yel rem", remaining, 2);
        chk("t4 yel sc", state_change, 1);
        meas("t4 yel", RED, 8);
        adv(40);
        chk("t4 hold st", {30'b0, traffic_state}, 0);
        chk("t4 hold rem", remaining, 1);
        emerg = 1'b0;
        adv(1);
        chk("t4 reload rem", remaining, 3);
        chk("t4 reload sc", state_change, 0);
        meas("t4 red full", GRN, 12);

        // 5: enable freeze mid-GREEN, then emergency while frozen
        adv(9);
        chk("t5 rem3", remaining, 3);
        enable = 1'b0;
        adv(50);
        chk("t5 frz st", {30'b0, traffic_state}, 1);
        chk("t5 frz rem", remaining, 3);
        enable = 1'b1;
        meas("t5 grn", YEL, 11);
        meas("t5 yel", RED, 8);
        meas("t5 red", GRN, 12);
        adv(9);
        enable = 1'b0;
        adv(5);
        emerg = 1'b1;
        adv(1);
        emerg = 1'b0;
        chk("t5 em st", {30'b0, traffic_state}, 2);
        chk("t5 em rem", remaining, 2);
        chk("t5 em sc", state_change, 1);
        adv(20);
        chk("t5 em frz st", {30'b0, traffic_state}, 2);
        chk("t5 em frz rem", remaining, 2);
        enable = 1'b1;
        meas("t5 em yel", RED, 8);

        // request on the tick that ends GREEN: GREEN not shortened, served next RED
        meas("t6a red", GRN, 12);
        adv(19);
        ped_req = 1'b1;
        adv(1);
        ped_req = 1'b0;
        chk("t6a yel st", {30'b0, traffic_state}, 2);
        chk("t6a yel sc", state_change, 1);
        meas("t6a yel", RED, 8);
        chk("t6a ack", ped_ack, 1);

        // 6: reset mid-YELLOW with a pending request
        meas("t6 red", GRN, 12);
        adv(19);
        ped_req = 1'b1;
        adv(1);
        ped_req = 1'b0;
        chk("t6 yel st", {30'b0, traffic_state}, 2);
        adv(3);
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        chk("t6 rst st", {30'b0, traffic_state}, 0);
        chk("t6 rst rem", remaining, 3);
        chk("t6 rst walk", ped_walk, 0);
        chk("t6 rst sc", state_change, 0);
        meas("t6 red", GRN, 12);
        meas("t6 grn", YEL, 20);
        meas("t6 yel", RED, 8);
        chk("t6 no ack", ped_ack, 0);
        chk("t6 no walk", ped_walk, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
